// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; result after WIDTH run cycles, done pulses the cycle after.
// Optional two's-complement mode via DIV_SIGNED_EN (magnitudes in, sign fix-up at the last step).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // One restoring step: trial subtract in WIDTH+1 bits, its MSB is the borrow.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, div_q};
    assign qbit     = ~trial[WIDTH];
    assign rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {dvd_q[WIDTH-2:0], qbit};

`ifdef DIV_SIGNED_EN
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
`else
    assign abs_a = a;
    assign abs_b = b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        rem_d   = '0;
                        dvd_d   = abs_a;
                        div_d   = abs_b;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_RUN;
`ifdef DIV_SIGNED_EN
                        qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        rneg_d  = a[WIDTH-1];
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
`ifdef DIV_SIGNED_EN
                    q_d = qneg_q ? -quo_step : quo_step;
                    r_d = rneg_q ? -rem_step : rem_step;
`else
                    q_d = quo_step;
                    r_d = rem_step;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic reference model checked every cycle plus literal expectations.
module tb_seq_divider;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] q, r;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] qo, output logic [W-1:0] ro);
        int sx, sy;
        if (y == '0) begin
            qo = '1;
            ro = x;
        end else begin
`ifdef DIV_SIGNED_EN
            sx = int'($signed(x));
            sy = int'($signed(y));
`else
            sx = int'(x);
            sy = int'(y);
`endif
            qo = W'(sx / sy);
            ro = W'(sx % sy);
        end
    endfunction

    // Reference: count of busy cycles left, a done flag, and the held results.
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_dbz  = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            ref_div(a, b, p_q, p_r);
            if (b == '0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b1;
            end else begin
                m_dbz = 1'b0; m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(m_left > 0));
            chk("done", int'(done), int'(m_done));
            chk("q", int'(q), int'(m_q));
            chk("r", int'(r), int'(m_r));
            chk("dbz", int'(dbz), int'(m_dbz));
        end
    end

    // Called on a negedge; a/b are scrambled during RUN to show they are not re-read.
    task automatic run_div(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input int eq, input int er, input int edbz, input int elat,
                           input string nm);
        int n;
        start = 1'b1; a = ai; b = bi;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, elat);
        chk({nm, " q"}, int'(q), eq);
        chk({nm, " r"}, int'(r), er);
        chk({nm, " dbz"}, int'(dbz), edbz);
        @(negedge clk);
    endtask

    task automatic count_done(input int cycles, output int nd, output int lq, output int lr);
        nd = 0; lq = -1; lr = -1;
        for (int i = 0; i < cycles; i++) begin
            if (done) begin
                nd++; lq = int'(q); lr = int'(r);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int nd, lq, lr;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset q", int'(q), 0);
        chk("reset r", int'(r), 0);
        chk("reset dbz", int'(dbz), 0);
        rst = 1'b0;
        chk_en = 1'b1;

`ifdef DIV_SIGNED_EN
        run_div(4'h9, 4'h2, 'hD, 'hF, 0, 5, "-7/2");
        run_div(4'h7, 4'hE, 'hD, 'h1, 0, 5, "7/-2");
        run_div(4'h8, 4'hF, 'h8, 'h0, 0, 5, "-8/-1");
        run_div(4'h6, 4'h3, 2, 0, 0, 5, "6/3");
        run_div(4'hB, 4'h0, 'hF, 'hB, 1, 1, "-5/0");
        run_div(4'hA, 4'hD, 2, 0, 0, 5, "-6/-3");
`else
        run_div(13, 3, 4, 1, 0, 5, "13/3");
        run_div(7, 0, 15, 7, 1, 1, "7/0");
        run_div(9, 3, 3, 0, 0, 5, "9/3");
        run_div(2, 9, 0, 2, 0, 5, "2/9");
        run_div(15, 1, 15, 0, 0, 5, "15/1");
        run_div(15, 15, 1, 0, 0, 5, "15/15");
        run_div(0, 5, 0, 0, 0, 5, "0/5");

        // start and new operands during RUN must be ignored
        start = 1'b1; a = 13; b = 3;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 1; b = 1;
        @(negedge clk); start = 1'b0; a = 5; b = 2;
        count_done(8, nd, lq, lr);
        chk("ignored start done count", nd, 1);
        chk("ignored start q", lq, 4);
        chk("ignored start r", lr, 1);

        // reset in RUN cycle 2 aborts the division
        start = 1'b1; a = 13; b = 3;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort q", int'(q), 0);
        chk("abort r", int'(r), 0);
        count_done(8, nd, lq, lr);
        chk("abort done count", nd, 0);
        run_div(10, 4, 2, 2, 0, 5, "10/4");

        // start held high: back-to-back every WIDTH+2 cycles
        start = 1'b1; a = 6; b = 2;
        count_done(1, nd, lq, lr);
        count_done(2 * (W + 2) - 1, nd, lq, lr);
        start = 1'b0;
        chk("back-to-back done count", nd, 2);
        chk("back-to-back q", lq, 3);
        repeat (W + 3) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
